// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with per-byte write enables,
// optional hardwired-zero entry 0 and a post-reset clear sequencer.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wbe,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic                       init_busy,
  output logic                       wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NBYTE = DATA_W / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt, cnt_d;
  logic                busy_d, drop_d;
  logic                clr_en, wr_en;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Sequencer register: reset restarts the clear walk from entry 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt   <= '0;
      init_busy <= 1'b1;
      wr_drop   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt   <= cnt_d;
      init_busy <= busy_d;
      wr_drop   <= drop_d;
    end
  end

  // Next-state: clear walk, write qualification and drop flag
  always_comb begin
    state_d = state_q;
    cnt_d   = clr_cnt;
    busy_d  = init_busy;
    drop_d  = 1'b0;
    clr_en  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_en = 1'b1;
        cnt_d  = clr_cnt + 1'b1;
        // a write with no byte lanes enabled is a no-op, never a drop
        drop_d = we && (|wbe);
        if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
          state_d = READY;
          busy_d  = 1'b0;
        end
      end
      READY: begin
        busy_d = 1'b0;
        // entry-0 discards are silent: they do not raise wr_drop
        wr_en  = we && (|wbe) && !((ZERO_REG != 0) && (waddr == '0));
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // Storage: clear walk has priority; otherwise byte-masked write
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en) begin
        mem[clr_cnt] <= '0;
      end else if (wr_en) begin
        for (int k = 0; k < NBYTE; k++) begin
          if (wbe[k]) mem[waddr][k*8 +: 8] <= wdata[k*8 +: 8];
        end
      end
    end
  end

  // Independent asynchronous read ports
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] word;

    assign ra = raddr[p*ADDR_W +: ADDR_W];

    // Read mux: storage, optional forwarding, then busy / zero-entry gate
    always_comb begin
      word = mem[ra];
`ifdef REGFILE_BYPASS_EN
      if ((state_q == READY) && we && (ra == waddr)) begin
        for (int k = 0; k < NBYTE; k++) begin
          if (wbe[k]) word[k*8 +: 8] = wdata[k*8 +: 8];
        end
      end
`else
`endif
      if (init_busy || ((ZERO_REG != 0) && (ra == '0))) word = '0;
    end

    assign rdata[p*DATA_W +: DATA_W] = word;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (default params).
// Honours REGFILE_BYPASS_EN for same-cycle read expectations.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wbe;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic              init_busy;
  logic              wr_drop;

  logic [DW-1:0] rd0, rd1;
  assign rd0 = rdata[DW-1:0];
  assign rd1 = rdata[2*DW-1:DW];

  int passed = 0;
  int total  = 0;
  int n;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr(raddr), .rdata(rdata), .init_busy(init_busy), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // one rising edge, then settle 1ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  // count edges until init_busy falls, bounded
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (init_busy && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; wbe = '0;
    set_rd(5'd5, 5'd3);

    // reset state
    tick(); tick();
    chk("rst_busy", {31'b0, init_busy}, 32'd1);
    chk("rst_drop", {31'b0, wr_drop}, 32'd0);
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_rd1", rd1, 32'h0);

    // clear takes exactly DEPTH edges
    rst = 1'b0;
    wait_ready(n);
    chk("clear_len", n, 32);

    // every entry reads zero on both ports
    for (int i = 0; i < 32; i++) begin
      set_rd(i[AW-1:0], 5'(31 - i));
      #1;
      chk("clr_rd0", rd0, 32'h0);
      chk("clr_rd1", rd1, 32'h0);
    end

    // full word write to 5
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; wbe = 4'hF;
    set_rd(5'd5, 5'd4);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("full_same", rd0, 32'hDEADBEEF);
`else
    chk("full_same", rd0, 32'h0);
`endif
    tick();
    we = 1'b0;
    #1;
    chk("full_rd0", rd0, 32'hDEADBEEF);
    chk("full_rd1", rd1, 32'h0);
    chk("full_drop", {31'b0, wr_drop}, 32'd0);

    // byte-enable merge
    we = 1'b1; wdata = 32'h11223344; wbe = 4'b0101;
    tick();
    we = 1'b0;
    #1;
    chk("be_merge", rd0, 32'hDE22BE44);

    // we with no byte lanes: no-op, no drop
    we = 1'b1; wdata = 32'h0; wbe = 4'h0;
    tick();
    we = 1'b0;
    #1;
    chk("be_none", rd0, 32'hDE22BE44);
    chk("be_none_drop", {31'b0, wr_drop}, 32'd0);

    // hardwired zero entry
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; wbe = 4'hF;
    set_rd(5'd0, 5'd0);
    #1;
    chk("zero_same", rd0, 32'h0);
    tick();
    we = 1'b0;
    #1;
    chk("zero_rd0", rd0, 32'h0);
    chk("zero_rd1", rd1, 32'h0);
    chk("zero_drop", {31'b0, wr_drop}, 32'd0);

    // both ports on the same address
    we = 1'b1; waddr = 5'd3; wdata = 32'h12345678; wbe = 4'hF;
    tick();
    we = 1'b0;
    set_rd(5'd3, 5'd3);
    #1;
    chk("same_rd0", rd0, 32'h12345678);
    chk("same_rd1", rd1, 32'h12345678);

    // same-cycle read of the written address
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; wbe = 4'hF;
    set_rd(5'd7, 5'd6);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_same", rd0, 32'hA5A5A5A5);
`else
    chk("byp_same", rd0, 32'h0);
`endif
    chk("byp_other", rd1, 32'h0);
    tick();
    we = 1'b0;
    #1;
    chk("byp_next", rd0, 32'hA5A5A5A5);

    // partial same-cycle write: merged word vs old word
    we = 1'b1; waddr = 5'd5; wdata = 32'h99000000; wbe = 4'b1000;
    set_rd(5'd5, 5'd7);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_part", rd0, 32'h9922BE44);
`else
    chk("byp_part", rd0, 32'hDE22BE44);
`endif
    tick();
    we = 1'b0;
    #1;
    chk("part_next", rd0, 32'h9922BE44);

    // reset again: busy gate hides stored data immediately
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("gate_busy", {31'b0, init_busy}, 32'd1);
    chk("gate_rd0", rd0, 32'h0);
    chk("gate_rd1", rd1, 32'h0);

    // write during clear cycle 10 is dropped for one cycle
    for (int i = 0; i < 10; i++) tick();
    we = 1'b1; waddr = 5'd31; wdata = 32'hFFFFFFFF; wbe = 4'hF;
    tick();
    we = 1'b0;
    #1;
    chk("drop_pulse", {31'b0, wr_drop}, 32'd1);
    tick();
    chk("drop_end", {31'b0, wr_drop}, 32'd0);

    // reset at clear cycle 20 restarts the full walk
    for (int i = 0; i < 8; i++) tick();
    chk("mid_busy", {31'b0, init_busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(n);
    chk("restart_len", n, 32);

    // previously written entries were cleared, dropped write left no trace
    set_rd(5'd5, 5'd31);
    #1;
    chk("post_rd5", rd0, 32'h0);
    chk("post_rd31", rd1, 32'h0);
    set_rd(5'd7, 5'd3);
    #1;
    chk("post_rd7", rd0, 32'h0);
    chk("post_rd3", rd1, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
